iencoder: RTL and testbench



---
 rtl/copperv_pkg.sv | 118 +++++++++++
 rtl/iencoder_skid.sv | 65 ++++++
 rtl/iencoder.sv | 121 ++++++++++++
 tb/tb_iencoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/copperv_pkg.sv
// Shared copperv constants: opcodes, decoded inst_type/funct codes and the
// RV32I funct3/funct7 field values used by the instruction encoder.
package copperv_pkg;

  localparam logic [6:0] opcode_lui    = 7'b0110111;
  localparam logic [6:0] opcode_auipc  = 7'b0010111;
  localparam logic [6:0] opcode_jal    = 7'b1101111;
  localparam logic [6:0] opcode_jalr   = 7'b1100111;
  localparam logic [6:0] opcode_branch = 7'b1100011;
  localparam logic [6:0] opcode_load   = 7'b0000011;
  localparam logic [6:0] opcode_store  = 7'b0100011;
  localparam logic [6:0] opcode_int_imm = 7'b0010011;
  localparam logic [6:0] opcode_int_reg = 7'b0110011;

  localparam logic [3:0] inst_type_imm     = 4'd0;
  localparam logic [3:0] inst_type_int_imm = 4'd1;
  localparam logic [3:0] inst_type_int_reg = 4'd2;
  localparam logic [3:0] inst_type_branch  = 4'd3;
  localparam logic [3:0] inst_type_store   = 4'd4;
  localparam logic [3:0] inst_type_load    = 4'd5;
  localparam logic [3:0] inst_type_jal     = 4'd6;
  localparam logic [3:0] inst_type_auipc   = 4'd7;
  localparam logic [3:0] inst_type_jalr    = 4'd8;
  localparam logic [3:0] inst_type_fence   = 4'd9;

  localparam logic [4:0] funct_add    = 5'd0;
  localparam logic [4:0] funct_sub    = 5'd1;
  localparam logic [4:0] funct_sll    = 5'd2;
  localparam logic [4:0] funct_slt    = 5'd3;
  localparam logic [4:0] funct_sltu   = 5'd4;
  localparam logic [4:0] funct_xor    = 5'd5;
  localparam logic [4:0] funct_srl    = 5'd6;
  localparam logic [4:0] funct_sra    = 5'd7;
  localparam logic [4:0] funct_or     = 5'd8;
  localparam logic [4:0] funct_and    = 5'd9;
  localparam logic [4:0] funct_eq     = 5'd10;
  localparam logic [4:0] funct_neq    = 5'd11;
  localparam logic [4:0] funct_lt     = 5'd12;
  localparam logic [4:0] funct_gte    = 5'd13;
  localparam logic [4:0] funct_ltu    = 5'd14;
  localparam logic [4:0] funct_gteu   = 5'd15;
  localparam logic [4:0] funct_byte   = 5'd16;
  localparam logic [4:0] funct_hword  = 5'd17;
  localparam logic [4:0] funct_word   = 5'd18;
  localparam logic [4:0] funct_byteu  = 5'd19;
  localparam logic [4:0] funct_hwordu = 5'd20;

  localparam logic [2:0] funct3_add  = 3'd0;
  localparam logic [2:0] funct3_sll  = 3'd1;
  localparam logic [2:0] funct3_slt  = 3'd2;
  localparam logic [2:0] funct3_sltu = 3'd3;
  localparam logic [2:0] funct3_xor  = 3'd4;
  localparam logic [2:0] funct3_sr   = 3'd5;
  localparam logic [2:0] funct3_or   = 3'd6;
  localparam logic [2:0] funct3_and  = 3'd7;
  localparam logic [2:0] funct3_eq   = 3'd0;
  localparam logic [2:0] funct3_neq  = 3'd1;
  localparam logic [2:0] funct3_lt   = 3'd4;
  localparam logic [2:0] funct3_gte  = 3'd5;
  localparam logic [2:0] funct3_ltu  = 3'd6;
  localparam logic [2:0] funct3_gteu = 3'd7;
  localparam logic [2:0] funct3_byte   = 3'd0;
  localparam logic [2:0] funct3_hword  = 3'd1;
  localparam logic [2:0] funct3_word   = 3'd2;
  localparam logic [2:0] funct3_byteu  = 3'd4;
  localparam logic [2:0] funct3_hwordu = 3'd5;

  localparam logic [6:0]  funct7_alt = 7'd32;
  localparam logic [31:0] fence_inst = 32'h0FF0000F;

  // Result is {legal, funct3}.
  function automatic logic [3:0] alu_funct3(input logic [4:0] f);
    case (f)
      funct_add, funct_sub: return {1'b1, funct3_add};
      funct_sll:            return {1'b1, funct3_sll};
      funct_slt:            return {1'b1, funct3_slt};
      funct_sltu:           return {1'b1, funct3_sltu};
      funct_xor:            return {1'b1, funct3_xor};
      funct_srl, funct_sra: return {1'b1, funct3_sr};
      funct_or:             return {1'b1, funct3_or};
      funct_and:            return {1'b1, funct3_and};
      default:              return 4'b0;
    endcase
  endfunction

  function automatic logic [3:0] branch_funct3(input logic [4:0] f);
    case (f)
      funct_eq:   return {1'b1, funct3_eq};
      funct_neq:  return {1'b1, funct3_neq};
      funct_lt:   return {1'b1, funct3_lt};
      funct_gte:  return {1'b1, funct3_gte};
      funct_ltu:  return {1'b1, funct3_ltu};
      funct_gteu: return {1'b1, funct3_gteu};
      default:    return 4'b0;
    endcase
  endfunction

  // Stores only accept the signed widths; loads also take the unsigned ones.
  function automatic logic [3:0] mem_funct3(input logic [4:0] f, input logic is_load);
    case (f)
      funct_byte:   return {1'b1, funct3_byte};
      funct_hword:  return {1'b1, funct3_hword};
      funct_word:   return {1'b1, funct3_word};
      funct_byteu:  return {is_load, funct3_byteu};
      funct_hwordu: return {is_load, funct3_hwordu};
      default:      return 4'b0;
    endcase
  endfunction

  function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
    logic signed [31:0] sv;
    logic signed [31:0] lim;
    sv  = $signed(v);
    lim = 32'sd1 <<< (nbits - 1);
    return (sv >= -lim) && (sv < lim);
  endfunction

endpackage

// File: rtl/iencoder_skid.sv
// Two-entry valid/ready register: main output stage plus one skid entry so
// the upstream can keep streaming while the consumer stalls for a cycle.
module iencoder_skid #(
  parameter int unsigned Width = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             main_valid_q, main_valid_d;
  logic [Width-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             in_accept, out_xfer;

  assign in_ready_o  = !skid_valid_q && !rst_i;
  assign in_accept   = in_valid_i && in_ready_o;
  assign out_xfer    = main_valid_q && out_ready_i;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!main_valid_q || out_xfer) begin
      // Skid holds the older word, so it always wins the main slot.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/iencoder.sv
// Encodes decoded copperv fields back into an RV32I instruction word.
// Define IENCODER_RANGE_CHECK_EN to flag immediates that do not fit their field.
module iencoder
  import copperv_pkg::*;
#(
  parameter int unsigned inst_width      = 32,
  parameter int unsigned imm_width       = 32,
  parameter int unsigned inst_type_width = 4,
  parameter int unsigned reg_width       = 5,
  parameter int unsigned funct_width     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [inst_type_width-1:0] in_inst_type,
  input  logic [funct_width-1:0]     in_funct,
  input  logic [reg_width-1:0]       in_rd,
  input  logic [reg_width-1:0]       in_rs1,
  input  logic [reg_width-1:0]       in_rs2,
  input  logic [imm_width-1:0]       in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [inst_width-1:0]      out_inst,
  output logic                       out_err
);

`ifdef IENCODER_RANGE_CHECK_EN
  localparam bit range_check_en = 1'b1;
`else
  localparam bit range_check_en = 1'b0;
`endif

  logic [inst_width-1:0] enc_inst;
  logic                  type_err, range_err, enc_err;
  logic [3:0]            alu_f3, br_f3, mem_f3;
  logic                  is_shift;

  assign alu_f3   = alu_funct3(in_funct);
  assign br_f3    = branch_funct3(in_funct);
  assign mem_f3   = mem_funct3(in_funct, in_inst_type == inst_type_load);
  assign is_shift = (in_funct == funct_sll) || (in_funct == funct_srl) || (in_funct == funct_sra);

  always_comb begin
    enc_inst  = '0;
    type_err  = 1'b0;
    range_err = 1'b0;
    case (in_inst_type)
      inst_type_imm, inst_type_auipc: begin
        enc_inst  = {in_imm[31:12], in_rd,
                     (in_inst_type == inst_type_imm) ? opcode_lui : opcode_auipc};
        range_err = |in_imm[11:0];
      end
      inst_type_jal: begin
        enc_inst  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opcode_jal};
        range_err = !fits_signed(in_imm, 21) || in_imm[0];
      end
      inst_type_jalr: begin
        enc_inst  = {in_imm[11:0], in_rs1, 3'd0, in_rd, opcode_jalr};
        range_err = !fits_signed(in_imm, 12);
      end
      inst_type_int_imm: begin
        type_err = !alu_f3[3] || (in_funct == funct_sub);
        if (is_shift) begin
          enc_inst  = {(in_funct == funct_sra) ? funct7_alt : 7'd0, in_imm[4:0], in_rs1,
                       alu_f3[2:0], in_rd, opcode_int_imm};
          range_err = |in_imm[31:5];
        end else begin
          enc_inst  = {in_imm[11:0], in_rs1, alu_f3[2:0], in_rd, opcode_int_imm};
          range_err = !fits_signed(in_imm, 12);
        end
      end
      inst_type_int_reg: begin
        type_err = !alu_f3[3];
        enc_inst = {((in_funct == funct_sub) || (in_funct == funct_sra)) ? funct7_alt : 7'd0,
                    in_rs2, in_rs1, alu_f3[2:0], in_rd, opcode_int_reg};
      end
      inst_type_branch: begin
        type_err  = !br_f3[3];
        enc_inst  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, br_f3[2:0], in_imm[4:1],
                     in_imm[11], opcode_branch};
        range_err = !fits_signed(in_imm, 13) || in_imm[0];
      end
      inst_type_store: begin
        type_err  = !mem_f3[3];
        enc_inst  = {in_imm[11:5], in_rs2, in_rs1, mem_f3[2:0], in_imm[4:0], opcode_store};
        range_err = !fits_signed(in_imm, 12);
      end
      inst_type_load: begin
        type_err  = !mem_f3[3];
        enc_inst  = {in_imm[11:0], in_rs1, mem_f3[2:0], in_rd, opcode_load};
        range_err = !fits_signed(in_imm, 12);
      end
      inst_type_fence: enc_inst = fence_inst;
      default:         type_err = 1'b1;
    endcase
  end

  assign enc_err = type_err || (range_check_en && range_err);

  logic [inst_width:0] skid_in, skid_out;

  // An erroring word is forced to zero so it can never be executed by mistake.
  assign skid_in  = {enc_err, enc_err ? {inst_width{1'b0}} : enc_inst};
  assign out_err  = skid_out[inst_width];
  assign out_inst = skid_out[inst_width-1:0];

  iencoder_skid #(
    .Width(inst_width + 1)
  ) u_skid (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (skid_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (skid_out)
  );

endmodule

// File: tb/tb_iencoder.sv
// Directed bench for iencoder: encoding vector table, backpressure through the
// skid entry, and synchronous reset with both entries occupied.
module tb_iencoder;
  import copperv_pkg::*;

`ifdef IENCODER_RANGE_CHECK_EN
  localparam bit rc = 1'b1;
`else
  localparam bit rc = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0]  in_inst_type;
  logic [4:0]  in_funct, in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iencoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst_type(in_inst_type),
    .in_funct    (in_funct),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_err     (out_err)
  );

  typedef struct {
    logic [3:0]  t;
    logic [4:0]  f;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid     = 1'b1;
    in_inst_type = v.t;
    in_funct     = v.f;
    in_rd        = v.rd;
    in_rs1       = v.rs1;
    in_rs2       = v.rs2;
    in_imm       = v.imm;
  endtask

  initial begin
    vecs[0]  = '{inst_type_int_imm, funct_add, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0};
    vecs[1]  = '{inst_type_int_reg, funct_sub, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 1'b0};
    vecs[2]  = '{inst_type_int_imm, funct_sra, 5'd5, 5'd6, 5'd0, 32'h3, 32'h40335293, 1'b0};
    vecs[3]  = '{inst_type_branch, funct_eq, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
    vecs[4]  = '{inst_type_jal, funct_add, 5'd1, 5'd0, 5'd0, 32'h800, 32'h001000EF, 1'b0};
    vecs[5]  = '{inst_type_store, funct_byteu, 5'd0, 5'd1, 5'd2, 32'h0, 32'h0, 1'b1};
    vecs[6]  = '{inst_type_branch, funct_eq, 5'd0, 5'd1, 5'd2, 32'h3,
                 rc ? 32'h0 : 32'h00208163, rc};
    vecs[7]  = '{inst_type_int_reg, funct_eq, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 1'b1};
    vecs[8]  = '{inst_type_imm, funct_add, 5'd7, 5'd0, 5'd0, 32'h12345000, 32'h123453B7, 1'b0};
    vecs[9]  = '{inst_type_fence, funct_add, 5'd9, 5'd9, 5'd9, 32'h1234, 32'h0FF0000F, 1'b0};
    vecs[10] = '{inst_type_store, funct_word, 5'd0, 5'd2, 5'd3, 32'h8, 32'h00312423, 1'b0};
    vecs[11] = '{inst_type_load, funct_hwordu, 5'd4, 5'd5, 5'd0, 32'h10, 32'h0102D203, 1'b0};
    vecs[12] = '{4'd15, funct_add, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0, 1'b1};
    vecs[13] = '{inst_type_jalr, funct_add, 5'd1, 5'd2, 5'd0, 32'h4, 32'h004100E7, 1'b0};
    vecs[14] = '{inst_type_int_imm, funct_sub, 5'd1, 5'd2, 5'd0, 32'h1, 32'h0, 1'b1};
    vecs[15] = '{inst_type_int_imm, funct_add, 5'd1, 5'd2, 5'd0, 32'h800,
                 rc ? 32'h0 : 32'h80010093, rc};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(vecs[0]);
    in_valid = 1'b0;
    step();
    step();
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_inst", out_inst, 32'd0);
    check("rst out_err", {31'd0, out_err}, 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back stream at full throughput: each word appears one cycle after accept.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      step();
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d out_inst", i), out_inst, vecs[i].exp_inst);
      check($sformatf("vec%0d out_err", i), {31'd0, out_err}, {31'd0, vecs[i].exp_err});
    end
    in_valid = 1'b0;
    step();
    check("drain out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A, B, C with consumer stalled.
    out_ready = 1'b0;
    drive(vecs[0]);
    step();
    check("bp A in main", out_inst, vecs[0].exp_inst);
    check("bp in_ready after A", {31'd0, in_ready}, 32'd1);
    drive(vecs[1]);
    step();
    check("bp in_ready after B", {31'd0, in_ready}, 32'd0);
    drive(vecs[2]);
    step();
    check("bp C stalled in_ready", {31'd0, in_ready}, 32'd0);
    check("bp A held", out_inst, vecs[0].exp_inst);
    check("bp A valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    check("bp B out", out_inst, vecs[1].exp_inst);
    check("bp in_ready reopen", {31'd0, in_ready}, 32'd1);
    step();
    check("bp C out", out_inst, vecs[2].exp_inst);
    check("bp C valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    step();
    check("bp idle", {31'd0, out_valid}, 32'd0);

    // Reset with main and skid both full.
    out_ready = 1'b0;
    drive(vecs[3]);
    step();
    drive(vecs[4]);
    step();
    check("rstfill in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid-rst in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-rst out_inst", out_inst, 32'd0);
    check("mid-rst in_ready after", {31'd0, in_ready}, 32'd1);
    step();
    check("no stale word", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
